// File: rtl/mmu_req_arbiter.sv
// -----------------------------------------------------------------------------
// mmu_req_arbiter
//
// Shares one address-translation path between the instruction-fetch (IF) and
// data-access (MEM) requesters. One request is accepted at a time. Its vaddr is
// latched and driven to the DMW/direct translator. If the translator needs the
// page table, one TLB lookup is issued and its result is resolved into a
// physical address plus an exception code. Both requesters share a single
// response bus, and a per-owner strobe qualifies it.
//
// Ports
//   clk, resetn                        clock, async active-low reset
//   inst_req_valid/ready, inst_vaddr   IF request handshake + address
//   inst_resp_valid                    one-cycle IF result strobe
//   data_req_valid/ready, data_vaddr   MEM request handshake + address
//   data_we                            MEM request is a store
//   data_resp_valid                    one-cycle MEM result strobe
//   resp_paddr, resp_exc               result; holds until the next response
//   crmd_plv                           privilege level, sampled at accept
//   inst_flush                         cancel in-flight / pending IF response
//   tr_vaddr, tr_paddr, tr_using_pt    translator interface
//   tlb_req_valid, tlb_vpn             TLB lookup strobe + VPN
//   tlb_resp_valid, tlb_found, tlb_v,
//   tlb_d, tlb_plv, tlb_ppn            TLB result
//
// Exception codes: 0 none, 1 TLBR, 2 PI, 3 PPI, 4 PME, 5 TMO (TLB timeout).
// -----------------------------------------------------------------------------
module mmu_req_arbiter #(
  parameter int TLB_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req_valid,
  output logic        inst_req_ready,
  input  logic [31:0] inst_vaddr,
  output logic        inst_resp_valid,
  input  logic        data_req_valid,
  output logic        data_req_ready,
  input  logic [31:0] data_vaddr,
  input  logic        data_we,
  output logic        data_resp_valid,
  output logic [31:0] resp_paddr,
  output logic [2:0]  resp_exc,
  input  logic [1:0]  crmd_plv,
  input  logic        inst_flush,
  output logic [31:0] tr_vaddr,
  input  logic [31:0] tr_paddr,
  input  logic        tr_using_pt,
  output logic        tlb_req_valid,
  output logic [18:0] tlb_vpn,
  input  logic        tlb_resp_valid,
  input  logic        tlb_found,
  input  logic        tlb_v,
  input  logic        tlb_d,
  input  logic [1:0]  tlb_plv,
  input  logic [19:0] tlb_ppn
);

  localparam int TW = $clog2(TLB_TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LIMIT = TW'(TLB_TIMEOUT);

  localparam logic [2:0] EXC_NONE = 3'd0;
  localparam logic [2:0] EXC_TLBR = 3'd1;
  localparam logic [2:0] EXC_PI   = 3'd2;
  localparam logic [2:0] EXC_PPI  = 3'd3;
  localparam logic [2:0] EXC_PME  = 3'd4;
  localparam logic [2:0] EXC_TMO  = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_WAIT, S_RESP} state_t;
  typedef enum logic {OWN_INST = 1'b0, OWN_DATA = 1'b1} owner_t;

  state_t          state, state_nxt;
  owner_t          owner_q, rr_q;
  logic [31:0]     vaddr_q;
  logic            we_q;
  logic [1:0]      plv_q;
  logic            cancel_q;
  logic [TW-1:0]   timer_q;

  logic            idle;
  logic            inst_cand;
  logic            grant_inst, grant_data;
  logic [2:0]      tlb_exc;
  logic [31:0]     tlb_paddr;

  // ---------------------------------------------------------------------------
  // Arbitration. A flush blocks the IF request for that cycle. The round-robin
  // pointer only matters when both requesters are candidates. Gating with
  // resetn holds both readies low while reset is asserted.
  // ---------------------------------------------------------------------------
  assign idle       = (state == S_IDLE) && resetn;
  assign inst_cand  = inst_req_valid && !inst_flush;
  assign grant_inst = idle && inst_cand && (!data_req_valid || rr_q == OWN_INST);
  assign grant_data = idle && data_req_valid && (!inst_cand || rr_q == OWN_DATA);

  // ---------------------------------------------------------------------------
  // TLB result resolution. The first failing check in priority order wins.
  // Faulting lookups return paddr 0.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves
    // it unassigned and no latch is inferred.
    tlb_exc   = EXC_NONE;
    tlb_paddr = {tlb_ppn, vaddr_q[11:0]};
    if (!tlb_found)                tlb_exc = EXC_TLBR;
    else if (!tlb_v)               tlb_exc = EXC_PI;
    else if (plv_q > tlb_plv)      tlb_exc = EXC_PPI;
    else if (we_q && !tlb_d)       tlb_exc = EXC_PME;
    if (tlb_exc != EXC_NONE) tlb_paddr = '0;
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    else         state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (grant_inst || grant_data) state_nxt = S_CHECK;
      S_CHECK: state_nxt = tr_using_pt ? S_WAIT : S_RESP;
      S_WAIT:  if (tlb_resp_valid || timer_q == TIMER_LIMIT) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    inst_req_ready  = idle && !inst_flush && !grant_data;
    data_req_ready  = idle && !grant_inst;
    tlb_req_valid   = (state == S_CHECK) && tr_using_pt;
    // A flush in the RESP cycle itself also suppresses the IF strobe.
    inst_resp_valid = (state == S_RESP) && (owner_q == OWN_INST) && !cancel_q && !inst_flush;
    data_resp_valid = (state == S_RESP) && (owner_q == OWN_DATA);
  end

  assign tr_vaddr = vaddr_q;
  assign tlb_vpn  = vaddr_q[31:13];

  // ---------------------------------------------------------------------------
  // Datapath: request latch, timer, response registers, cancel flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vaddr_q    <= '0;
      we_q       <= 1'b0;
      plv_q      <= '0;
      owner_q    <= OWN_INST;
      rr_q       <= OWN_INST;
      cancel_q   <= 1'b0;
      timer_q    <= '0;
      resp_paddr <= '0;
      resp_exc   <= EXC_NONE;
    end else begin
      case (state)
        S_IDLE: begin
          cancel_q <= 1'b0;
          if (grant_inst) begin
            vaddr_q <= inst_vaddr;
            we_q    <= 1'b0;
            plv_q   <= crmd_plv;
            owner_q <= OWN_INST;
            rr_q    <= OWN_DATA;
          end else if (grant_data) begin
            vaddr_q <= data_vaddr;
            we_q    <= data_we;
            plv_q   <= crmd_plv;
            owner_q <= OWN_DATA;
            rr_q    <= OWN_INST;
          end
        end
        S_CHECK: begin
          if (!tr_using_pt) begin
            resp_paddr <= tr_paddr;
            resp_exc   <= EXC_NONE;
          end else begin
            timer_q <= '0;
          end
        end
        S_WAIT: begin
          timer_q <= timer_q + 1'b1;
          if (tlb_resp_valid) begin
            resp_paddr <= tlb_paddr;
            resp_exc   <= tlb_exc;
          end else if (timer_q == TIMER_LIMIT) begin
            resp_paddr <= '0;
            resp_exc   <= EXC_TMO;
          end
        end
        default: ;
      endcase

      // The transaction still runs to RESP so the TLB handshake stays clean.
      // Only the IF strobe is dropped.
      if (inst_flush && owner_q == OWN_INST && state != S_IDLE) cancel_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mmu_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mmu_req_arbiter
//
// Self-checking bench for mmu_req_arbiter. A transaction-level reference model
// turns each request description into its expected exception, paddr, latency
// window and strobe counts. Directed cases come first, followed by randomized
// transactions and a round-robin contention check.
// -----------------------------------------------------------------------------
module tb_mmu_req_arbiter;

  localparam int TLB_TIMEOUT = 15;
  localparam int BUDGET      = 24;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req_valid, inst_req_ready, inst_resp_valid;
  logic [31:0] inst_vaddr;
  logic        data_req_valid, data_req_ready, data_resp_valid, data_we;
  logic [31:0] data_vaddr;
  logic [31:0] resp_paddr;
  logic [2:0]  resp_exc;
  logic [1:0]  crmd_plv;
  logic        inst_flush;
  logic [31:0] tr_vaddr, tr_paddr;
  logic        tr_using_pt;
  logic        tlb_req_valid;
  logic [18:0] tlb_vpn;
  logic        tlb_resp_valid, tlb_found, tlb_v, tlb_d;
  logic [1:0]  tlb_plv;
  logic [19:0] tlb_ppn;

  mmu_req_arbiter #(.TLB_TIMEOUT(TLB_TIMEOUT)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req_valid(inst_req_valid), .inst_req_ready(inst_req_ready),
    .inst_vaddr(inst_vaddr), .inst_resp_valid(inst_resp_valid),
    .data_req_valid(data_req_valid), .data_req_ready(data_req_ready),
    .data_vaddr(data_vaddr), .data_we(data_we), .data_resp_valid(data_resp_valid),
    .resp_paddr(resp_paddr), .resp_exc(resp_exc), .crmd_plv(crmd_plv),
    .inst_flush(inst_flush), .tr_vaddr(tr_vaddr), .tr_paddr(tr_paddr),
    .tr_using_pt(tr_using_pt), .tlb_req_valid(tlb_req_valid), .tlb_vpn(tlb_vpn),
    .tlb_resp_valid(tlb_resp_valid), .tlb_found(tlb_found), .tlb_v(tlb_v),
    .tlb_d(tlb_d), .tlb_plv(tlb_plv), .tlb_ppn(tlb_ppn)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_inst;
    logic [31:0] va;
    bit          we;
    logic [1:0]  plv;
    bit          use_pt;
    logic [31:0] trp;
    bit          found, v, d;
    logic [1:0]  tplv;
    logic [19:0] ppn;
    int          delay;    // TLB response cycles after the lookup strobe; 0 = never
    int          flush_k;  // cycle after accept to pulse inst_flush; 0 = none
  } txn_t;

  int n_checks = 0;
  int n_fail   = 0;
  bit rr_model = 1'b0;     // 0 = inst next on contention, 1 = data

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the result of one transaction, derived from the
  // translation rules alone. Latency is counted in cycles after the accept edge.
  function automatic void ref_model(input txn_t t, output logic [2:0] exc,
                                    output logic [31:0] pa, output bit pa_known,
                                    output int lat_lo, output int lat_hi);
    exc = 3'd0; pa = t.trp; pa_known = 1'b1; lat_lo = 2; lat_hi = 2;
    if (t.use_pt) begin
      if (t.delay >= 1 && t.delay <= TLB_TIMEOUT) begin
        lat_lo = 2 + t.delay; lat_hi = lat_lo;
        if (!t.found)                 exc = 3'd1;
        else if (!t.v)                exc = 3'd2;
        else if (t.plv > t.tplv)      exc = 3'd3;
        else if (t.we && !t.d)        exc = 3'd4;
        pa       = {t.ppn, t.va[11:0]};
        pa_known = (exc == 3'd0);
      end else begin
        exc = 3'd5; pa = 32'h0;
        lat_lo = TLB_TIMEOUT + 2; lat_hi = TLB_TIMEOUT + 3;
      end
    end
  endfunction

  function automatic txn_t base_txn();
    txn_t t;
    t.is_inst = 1'b1; t.va = 32'h0; t.we = 1'b0; t.plv = 2'd0; t.use_pt = 1'b0;
    t.trp = 32'h0; t.found = 1'b1; t.v = 1'b1; t.d = 1'b1; t.tplv = 2'd0;
    t.ppn = 20'h0; t.delay = 0; t.flush_k = 0;
    return t;
  endfunction

  // Issues one request from IDLE and runs for BUDGET cycles. The call starts
  // and ends one time unit after a rising edge.
  task automatic run_txn(input txn_t t, input string tag);
    logic [2:0]  e_exc;
    logic [31:0] e_pa;
    bit          pa_known;
    int          lat_lo, lat_hi, req_k, resp_k, n_inst, n_data, n_tlb;
    logic [31:0] got_pa;
    logic [2:0]  got_exc;
    bit          cancelled;
    ref_model(t, e_exc, e_pa, pa_known, lat_lo, lat_hi);
    cancelled = t.is_inst && t.flush_k != 0;

    inst_req_valid = t.is_inst;
    data_req_valid = !t.is_inst;
    inst_vaddr     = t.is_inst ? t.va : ~t.va;
    data_vaddr     = t.is_inst ? ~t.va : t.va;
    data_we        = t.is_inst ? 1'b1 : t.we;   // an IF request must latch we=0
    crmd_plv       = t.plv;
    tr_using_pt    = t.use_pt;
    tr_paddr       = t.trp;
    tlb_found = t.found; tlb_v = t.v; tlb_d = t.d; tlb_plv = t.tplv; tlb_ppn = t.ppn;

    @(negedge clk);
    check({tag, "_ready"}, t.is_inst ? inst_req_ready : data_req_ready, 1);
    check({tag, "_other_ready"}, t.is_inst ? data_req_ready : inst_req_ready, 0);
    @(posedge clk); #1;
    rr_model = t.is_inst ? 1'b1 : 1'b0;
    inst_req_valid = 1'b0; data_req_valid = 1'b0;
    crmd_plv = ~t.plv;                           // must have been sampled at accept

    req_k = -1; resp_k = -1; n_inst = 0; n_data = 0; n_tlb = 0;
    got_pa = 32'hx; got_exc = 3'hx;
    for (int k = 1; k <= BUDGET; k++) begin
      tlb_resp_valid = (req_k > 0 && t.delay > 0 && k == req_k + t.delay);
      inst_flush     = (k == t.flush_k);
      @(negedge clk);
      if (k == 1) check({tag, "_tr_vaddr"}, tr_vaddr, t.va);
      if (tlb_req_valid) begin
        n_tlb++;
        if (req_k < 0) begin
          req_k = k;
          check({tag, "_tlb_vpn"}, 32'(tlb_vpn), 32'(t.va[31:13]));
        end
      end
      if (inst_resp_valid) n_inst++;
      if (data_resp_valid) n_data++;
      if ((inst_resp_valid || data_resp_valid) && resp_k < 0) begin
        resp_k = k; got_pa = resp_paddr; got_exc = resp_exc;
      end
      @(posedge clk); #1;
    end
    tlb_resp_valid = 1'b0; inst_flush = 1'b0;

    check({tag, "_tlb_reqs"}, n_tlb, t.use_pt ? 1 : 0);
    check({tag, "_inst_strobes"}, n_inst, (t.is_inst && !cancelled) ? 1 : 0);
    check({tag, "_data_strobes"}, n_data, t.is_inst ? 0 : 1);
    if (!cancelled) begin
      if (lat_lo == lat_hi) check({tag, "_latency"}, resp_k, lat_lo);
      else check({tag, "_latency_window"}, (resp_k >= lat_lo && resp_k <= lat_hi), 1);
      check({tag, "_exc"}, 32'(got_exc), 32'(e_exc));
      if (pa_known) check({tag, "_paddr"}, got_pa, e_pa);
      check({tag, "_paddr_hold"}, resp_paddr, got_pa);
    end
  endtask

  task automatic contention(input string tag);
    int grants = 0;
    inst_req_valid = 1'b1; data_req_valid = 1'b1; tr_using_pt = 1'b0;
    inst_vaddr = 32'h1000_0000; data_vaddr = 32'h2000_0000; data_we = 1'b0;
    for (int c = 0; c < 40 && grants < 4; c++) begin
      @(negedge clk);
      if (inst_req_ready || data_req_ready) begin
        check({tag, "_one_ready"}, 32'(inst_req_ready && data_req_ready), 0);
        check({tag, "_grant"}, 32'(data_req_ready), 32'(rr_model));
        rr_model = ~rr_model;
        grants++;
      end
      @(posedge clk); #1;
    end
    inst_req_valid = 1'b0; data_req_valid = 1'b0;
    check({tag, "_grant_count"}, grants, 4);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag, input int cycles);
    repeat (cycles) begin
      @(negedge clk);
      check({tag, "_no_strobe"}, 32'({inst_resp_valid, data_resp_valid, tlb_req_valid}), 0);
    end
  endtask

  initial begin
    txn_t t;
    logic [2:0]  e_exc;
    logic [31:0] e_pa;
    bit          pk;
    int          lo, hi;

    resetn = 1'b0;
    inst_req_valid = 0; data_req_valid = 0; inst_vaddr = 0; data_vaddr = 0; data_we = 0;
    crmd_plv = 0; inst_flush = 0; tr_paddr = 0; tr_using_pt = 0; tlb_resp_valid = 0;
    tlb_found = 0; tlb_v = 0; tlb_d = 0; tlb_plv = 0; tlb_ppn = 0;

    // Reset state
    @(negedge clk);
    check("rst_inst_ready", inst_req_ready, 0);
    check("rst_data_ready", data_req_ready, 0);
    check("rst_strobes", {inst_resp_valid, data_resp_valid, tlb_req_valid}, 0);
    check("rst_paddr", resp_paddr, 0);
    check("rst_exc", resp_exc, 0);
    check("rst_tr_vaddr", tr_vaddr, 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    // DMW hit
    t = base_txn(); t.va = 32'h1C00_0000; t.trp = 32'h0C00_0000;
    run_txn(t, "dmw");

    // TLB hit on a store
    t = base_txn(); t.is_inst = 0; t.we = 1; t.va = 32'h0040_1234; t.use_pt = 1;
    t.ppn = 20'h12345; t.delay = 3;
    run_txn(t, "tlb_hit");

    // TLB faults in priority order, and a clean load with d=0
    t.found = 0; run_txn(t, "tlbr");
    t.found = 1; t.v = 0; run_txn(t, "pi");
    t.v = 1; t.plv = 3; t.tplv = 0; run_txn(t, "ppi");
    t.plv = 0; t.d = 0; run_txn(t, "pme");
    t.we = 0; run_txn(t, "load_clean");
    t.is_inst = 1; t.we = 0; run_txn(t, "inst_d0");   // data_we is high, but an IF request is never a store

    // Timeout, then a late response arriving in IDLE
    t = base_txn(); t.is_inst = 0; t.use_pt = 1; t.va = 32'h8000_5000; t.delay = 0;
    run_txn(t, "tmo");
    tlb_resp_valid = 1'b1; tlb_found = 1; tlb_v = 1; tlb_ppn = 20'hABCDE;
    @(negedge clk);
    check("late_resp_no_strobe", {inst_resp_valid, data_resp_valid}, 0);
    @(posedge clk); #1;
    tlb_resp_valid = 1'b0;
    check_quiet("late_resp", 2);
    check("late_resp_exc_hold", resp_exc, 5);
    @(posedge clk); #1;

    // Flush during WAIT cancels an IF response but never a data one
    t = base_txn(); t.use_pt = 1; t.va = 32'h0123_4567; t.ppn = 20'h55555; t.delay = 6;
    t.flush_k = 3;
    run_txn(t, "flush_wait_inst");
    t.is_inst = 0;
    run_txn(t, "flush_wait_data");

    // Flush in IDLE blocks that cycle's IF grant
    inst_req_valid = 1'b1; inst_flush = 1'b1; tr_using_pt = 1'b0;
    @(negedge clk);
    check("flush_idle_ready", inst_req_ready, 0);
    inst_req_valid = 1'b0;
    @(posedge clk); #1;
    inst_flush = 1'b0;
    check_quiet("flush_idle", 3);
    @(posedge clk); #1;

    // Reset asserted during WAIT
    t = base_txn(); t.use_pt = 1; t.va = 32'h7777_0000;
    inst_req_valid = 1'b1; inst_vaddr = t.va; tr_using_pt = 1'b1;
    @(negedge clk);
    check("rst_wait_accept", inst_req_ready, 1);
    @(posedge clk); #1;
    inst_req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    check("rst_wait_ready", {inst_req_ready, data_req_ready}, 0);
    check_quiet("rst_wait_held", 2);
    @(posedge clk); #1;
    resetn = 1'b1; rr_model = 1'b0;
    check_quiet("rst_wait_after", 3);
    check("rst_wait_paddr", resp_paddr, 0);
    @(posedge clk); #1;

    // Contention straight after reset: inst, data, inst, data
    contention("rr_reset");

    // Randomized transactions
    for (int i = 0; i < 40; i++) begin
      t = base_txn();
      t.is_inst = $urandom_range(0, 1);
      t.va      = $urandom;
      t.we      = t.is_inst ? 1'b0 : 1'($urandom_range(0, 1));
      t.plv     = 2'($urandom_range(0, 3));
      t.use_pt  = $urandom_range(0, 1);
      t.trp     = $urandom;
      t.found   = ($urandom_range(0, 3) != 0);
      t.v       = ($urandom_range(0, 3) != 0);
      t.d       = $urandom_range(0, 1);
      t.tplv    = 2'($urandom_range(0, 3));
      t.ppn     = 20'($urandom);
      t.delay   = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 12);
      ref_model(t, e_exc, e_pa, pk, lo, hi);
      t.flush_k = ($urandom_range(0, 3) == 0) ? $urandom_range(1, lo - 1) : 0;
      run_txn(t, $sformatf("rnd%0d", i));
    end

    // Contention after random traffic starts from the model's pointer
    contention("rr_rand");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
